instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 111 +++++++++++
 tb/tb_instr_mem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream instruction loader: assembles little-endian 32-bit words from a
// handshaked byte source, writes them to instruction memory and stalls the CPU.
module instr_mem_loader #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              cpu_stall,
  output logic              done,
  output logic              error,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] DEPTH_W = 7'(DEPTH);

  state_t              state, state_next;
  logic [5:0]          count_q;
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          byte_idx;
  logic [31:0]         word_q;
  logic [7:0]          sum_q;
  logic                error_q;
  logic                start_ok;
  logic                xfer;
  logic                last_word;

  always_comb begin
    start_ok  = start && (word_count != 6'd0) && ({1'b0, word_count} <= DEPTH_W);
    xfer      = (state == RECV) && byte_valid;
    // Widened compare so word_idx+1 == DEPTH does not wrap to 0.
    last_word = ((7'(word_idx) + 7'd1) == {1'b0, count_q});
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RECV;
      RECV:    if (xfer && (byte_idx == 2'd3)) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : RECV;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready  = (state == RECV);
    mem_wr_en   = (state == WRITE);
    cpu_stall   = (state == RECV) || (state == WRITE);
    done        = (state == DONE);
    error       = error_q;
    mem_wr_addr = word_idx;
    mem_wr_data = word_q;
    checksum    = sum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      sum_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= (state == IDLE) && start && !start_ok;
      case (state)
        IDLE: begin
          if (start_ok) begin
            count_q  <= word_count;
            word_idx <= '0;
            byte_idx <= '0;
            sum_q    <= '0;
          end
        end
        RECV: begin
          if (xfer) begin
            word_q[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx                        <= byte_idx + 2'd1;
            sum_q                           <= sum_q + byte_data;
          end
        end
        WRITE: begin
          if (!last_word) word_idx <= word_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as words
// are sent and checked by a monitor when mem_wr_en fires.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        cpu_stall;
  logic        done;
  logic        error;
  logic [7:0]  checksum;

  instr_mem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .cpu_stall(cpu_stall), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned cyc = 0;
  int unsigned write_cnt, done_cnt, err_cnt, stall_cnt;
  int unsigned last_wr_cyc, done_cyc;
  logic [36:0] exp_q[$];
  logic [7:0]  exp_sum;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      write_cnt++;
      last_wr_cyc = cyc;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr=%0d data=%08h, required no write", mem_wr_addr, mem_wr_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({mem_wr_addr, mem_wr_data} !== e)
          $display("FAIL write_data: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   mem_wr_addr, mem_wr_data, e[36:32], e[31:0]);
        else pass_cnt++;
      end
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) err_cnt++;
    if (cpu_stall) stall_cnt++;
  end

  task automatic clear_counts();
    write_cnt = 0; done_cnt = 0; err_cnt = 0; stall_cnt = 0;
    last_wr_cyc = 0; done_cyc = 0; exp_sum = 8'h00;
  endtask

  task automatic do_start(input logic [5:0] wc);
    start = 1'b1; word_count = wc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int unsigned n = 0;
    byte_valid = 1'b1; byte_data = b;
    while (!byte_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!byte_ready) begin
      total_cnt++;
      $display("FAIL byte_ready_timeout: got byte_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    exp_sum = exp_sum + b;
    byte_valid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int unsigned i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total_cnt++;
    if (got !== req) $display("FAIL %s: got %0h, required %0h", name, got, req);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; word_count = 6'd1;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    total_cnt++; if (byte_ready !== 1'b0) $display("FAIL rst_byte_ready: got %b, required 0", byte_ready); else pass_cnt++;
    total_cnt++; if (mem_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b, required 0", mem_wr_en); else pass_cnt++;
    total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b, required 0", cpu_stall); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL rst_error: got %b, required 0", error); else pass_cnt++;
    total_cnt++; if (checksum !== 8'h00) $display("FAIL rst_checksum: got %h, required 00", checksum); else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (byte_ready !== 1'b0) $display("FAIL rst_priority: got byte_ready=%b, required 0", byte_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_counts();
    exp_q.push_back({5'd0, 32'h00000033});
    do_start(6'd1);
    send_word(32'h00000033, 1'b0);
    repeat (4) @(posedge clk); #1;
    total_cnt++; if (write_cnt !== 1) $display("FAIL b2b_writes: got %0d, required 1", write_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL b2b_done_count: got %0d, required 1", done_cnt); else pass_cnt++;
    total_cnt++; if (done_cyc !== last_wr_cyc + 1) $display("FAIL b2b_done_timing: got cycle %0d, required %0d", done_cyc, last_wr_cyc + 1); else pass_cnt++;
    total_cnt++; if (checksum !== 8'h33) $display("FAIL b2b_checksum: got %h, required 33", checksum); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 5) $display("FAIL b2b_latency: got %0d stall cycles, required 5", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_two_words();
    clear_counts();
    exp_q.push_back({5'd0, 32'h000080B3});
    exp_q.push_back({5'd1, 32'h0000A023});
    do_start(6'd2);
    send_word(32'h000080B3, 1'b0);
    send_word(32'h0000A023, 1'b0);
    repeat (4) @(posedge clk); #1;
    total_cnt++; if (write_cnt !== 2) $display("FAIL two_writes: got %0d, required 2", write_cnt); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 10) $display("FAIL two_stall: got %0d, required 10", stall_cnt); else pass_cnt++;
    total_cnt++; if (checksum !== exp_sum) $display("FAIL two_checksum: got %h, required %h", checksum, exp_sum); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL two_done: got %0d, required 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_bad_start();
    clear_counts();
    do_start(6'd0);
    @(posedge clk); #1;
    do_start(6'd33);
    repeat (3) @(posedge clk); #1;
    total_cnt++; if (err_cnt !== 2) $display("FAIL bad_error_pulses: got %0d, required 2", err_cnt); else pass_cnt++;
    total_cnt++; if (write_cnt !== 0) $display("FAIL bad_writes: got %0d, required 0", write_cnt); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 0) $display("FAIL bad_stall: got %0d, required 0", stall_cnt); else pass_cnt++;
    total_cnt++; if (checksum !== 8'hF6) $display("FAIL bad_checksum_hold: got %h, required f6", checksum); else pass_cnt++;
  endtask

  task automatic test_toggle_valid();
    clear_counts();
    exp_q.push_back({5'd0, 32'h00000033});
    do_start(6'd1);
    send_word(32'h00000033, 1'b1);
    repeat (4) @(posedge clk); #1;
    total_cnt++; if (write_cnt !== 1) $display("FAIL toggle_writes: got %0d, required 1", write_cnt); else pass_cnt++;
    total_cnt++; if (checksum !== 8'h33) $display("FAIL toggle_checksum: got %h, required 33", checksum); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    clear_counts();
    exp_q.push_back({5'd0, 32'hDEADBEEF});
    do_start(6'd3);
    send_word(32'hDEADBEEF, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total_cnt++; if (byte_ready !== 1'b0 || cpu_stall !== 1'b0 || mem_wr_en !== 1'b0 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL midrst_outputs: got ready=%b stall=%b wr=%b done=%b err=%b, required all 0",
               byte_ready, cpu_stall, mem_wr_en, done, error);
    else pass_cnt++;
    total_cnt++; if (checksum !== 8'h00) $display("FAIL midrst_checksum: got %h, required 00", checksum); else pass_cnt++;
    repeat (6) @(posedge clk); #1;
    total_cnt++; if (write_cnt !== 1) $display("FAIL midrst_no_write: got %0d writes, required 1", write_cnt); else pass_cnt++;
    exp_sum = 8'h00;
    exp_q.push_back({5'd0, 32'h12345678});
    do_start(6'd1);
    send_word(32'h12345678, 1'b0);
    repeat (4) @(posedge clk); #1;
    total_cnt++; if (write_cnt !== 2) $display("FAIL midrst_reload: got %0d writes, required 2", write_cnt); else pass_cnt++;
    total_cnt++; if (checksum !== exp_sum) $display("FAIL midrst_sum: got %h, required %h", checksum, exp_sum); else pass_cnt++;
  endtask

  task automatic test_full_depth();
    clear_counts();
    do_start(6'd32);
    for (int unsigned w = 0; w < 32; w++) begin
      logic [31:0] d;
      d = $urandom;
      exp_q.push_back({w[4:0], d});
      send_word(d, 1'b0);
      if (w == 5) begin
        do_start(6'd0);
        do_start(6'd1);
      end
    end
    repeat (4) @(posedge clk); #1;
    total_cnt++; if (write_cnt !== 32) $display("FAIL full_writes: got %0d, required 32", write_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL full_done: got %0d, required 1", done_cnt); else pass_cnt++;
    total_cnt++; if (err_cnt !== 0) $display("FAIL full_ignore_start: got %0d error pulses, required 0", err_cnt); else pass_cnt++;
    total_cnt++; if (checksum !== exp_sum) $display("FAIL full_checksum: got %h, required %h", checksum, exp_sum); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    clear_counts();
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_two_words();
    test_bad_start();
    test_toggle_valid();
    test_reset_mid_load();
    test_full_depth();
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
